// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer that owns PC and IR.
// Latency with zero-wait memories: ALU+WB 4, flag-only/NOP/branch 3, store 4, load 5 cycles.
// Backpressure: FETCH/MEM hold req stable until ack; a wait of TIMEOUT cycles traps to FAULT.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr = pc)
//   instr                 IR contents, fed to the instruction decoder
//   dec_*                 decoder results for the instruction held in IR
//   flags                 current NZCV {N,Z,C,V}
//   dmem_req/we/ack       data memory handshake
//   rf_we, flags_we       register-file / NZCV write strobes, gated to WB / EXEC
//   pc                    program counter
//   halted, fault         breakpoint halt / memory timeout (terminal until reset)
module cpu_seq_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  input  logic        dec_we,
  input  logic        dec_sets_flags,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_branch,
  input  logic [3:0]  dec_cond,
  input  logic [15:0] dec_br_offset,
  input  logic [3:0]  flags,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        flags_we,
  output logic [15:0] pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [15:0] BKPT_INSTR = 16'hBE00;
  // The wait counter counts cycles already spent without ack; the cycle in which
  // it would reach TIMEOUT is the last one allowed, and an ack there still wins.
  localparam logic [7:0]  LAST_WAIT  = TIMEOUT - 8'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_pass;
  logic        wait_expired;

  assign {flag_n, flag_z, flag_c, flag_v} = flags;
  assign wait_expired = (cnt_q == LAST_WAIT);

  // ARM condition-code evaluation; 1111 is treated as never so the branch
  // degenerates into a NOP.
  always_comb begin
    cond_pass = 1'b0;
    case (dec_cond)
      4'b0000: cond_pass = flag_z;                              // EQ
      4'b0001: cond_pass = ~flag_z;                             // NE
      4'b0010: cond_pass = flag_c;                              // CS
      4'b0011: cond_pass = ~flag_c;                             // CC
      4'b0100: cond_pass = flag_n;                              // MI
      4'b0101: cond_pass = ~flag_n;                             // PL
      4'b0110: cond_pass = flag_v;                              // VS
      4'b0111: cond_pass = ~flag_v;                             // VC
      4'b1000: cond_pass = flag_c & ~flag_z;                    // HI
      4'b1001: cond_pass = ~flag_c | flag_z;                    // LS
      4'b1010: cond_pass = (flag_n == flag_v);                  // GE
      4'b1011: cond_pass = (flag_n != flag_v);                  // LT
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);        // GT
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);         // LE
      4'b1110: cond_pass = 1'b1;                                // AL
      default: cond_pass = 1'b0;                                // NV
    endcase
  end

  // Next-state logic. The wait counter defaults to zero so it clears on ack
  // and on any state exit without extra bookkeeping.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = '0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + 16'd2;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        // pc already points past the breakpoint and is left there.
        state_d = (ir_q == BKPT_INSTR) ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        // Branch target is relative to the already-incremented pc.
        if (dec_branch && cond_pass) begin
          pc_d = pc_q + dec_br_offset;
        end
        if (dec_load || dec_store) begin
          state_d = S_MEM;
        end else if (dec_we) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        if (dmem_ack) begin
          state_d = dec_load ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: begin
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs: requests and strobes are decoded from the state register
  // only (qualified by the stable decoder fields), so reset or FAULT drops
  // them immediately.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_EXEC:  flags_we = dec_sets_flags;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_store;
      end
      S_WB:    rf_we  = 1'b1;
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = ir_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: the bench plays instruction memory, data
// memory and decoder, walking a table of instructions through the sequencer,
// then hand-written sequences for timeout, breakpoint and mid-access reset.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic        dec_we = 1'b0;
  logic        dec_sets_flags = 1'b0;
  logic        dec_load = 1'b0;
  logic        dec_store = 1'b0;
  logic        dec_branch = 1'b0;
  logic [3:0]  dec_cond = 4'hE;
  logic [15:0] dec_br_offset = '0;
  logic [3:0]  flags = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we;
  logic        flags_we;
  logic [15:0] pc;
  logic        halted;
  logic        fault;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(
    .RESET_PC(16'h0000),
    .TIMEOUT (8'd8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .dec_we        (dec_we),
    .dec_sets_flags(dec_sets_flags),
    .dec_load      (dec_load),
    .dec_store     (dec_store),
    .dec_branch    (dec_branch),
    .dec_cond      (dec_cond),
    .dec_br_offset (dec_br_offset),
    .flags         (flags),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .rf_we         (rf_we),
    .flags_we      (flags_we),
    .pc            (pc),
    .halted        (halted),
    .fault         (fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_h(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] ins;
    logic        we;
    logic        sf;
    logic        ld;
    logic        st;
    logic        br;
    logic [3:0]  cond;
    logic [15:0] off;
    logic [3:0]  flg;
    int          iw;     // fetch wait cycles before ack
    int          dw;     // data wait cycles before ack
    logic [15:0] addr;   // expected fetch address
    logic [15:0] nxt;    // expected next fetch address
    int          lat;    // cycles from first FETCH cycle to next fetch
    int          fw;     // flags_we cycles
    int          rw;     // rf_we cycles
    int          dreq;   // dmem_req cycles
    int          dwe;    // dmem_we cycles
  } vec_t;

  function automatic vec_t mk(
    input logic [15:0] ins, input logic we, input logic sf, input logic ld,
    input logic st, input logic br, input logic [3:0] cond, input logic [15:0] off,
    input logic [3:0] flg, input int iw, input int dw, input logic [15:0] addr,
    input logic [15:0] nxt, input int lat, input int fw, input int rw,
    input int dreq, input int dwe);
    vec_t v;
    v.ins = ins; v.we = we; v.sf = sf; v.ld = ld; v.st = st; v.br = br;
    v.cond = cond; v.off = off; v.flg = flg; v.iw = iw; v.dw = dw;
    v.addr = addr; v.nxt = nxt; v.lat = lat; v.fw = fw; v.rw = rw;
    v.dreq = dreq; v.dwe = dwe;
    return v;
  endfunction

  task automatic clear_inputs();
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
    dec_we = 1'b0; dec_sets_flags = 1'b0; dec_load = 1'b0; dec_store = 1'b0;
    dec_branch = 1'b0; dec_cond = 4'hE; dec_br_offset = '0; flags = '0;
  endtask

  // Asserts reset, checks the reset state, releases at a falling edge and
  // returns at the falling edge of the first FETCH cycle.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    clear_inputs();
    #1;
    chk_h({tag, "_rst_pc"}, pc, 16'h0000);
    chk_h({tag, "_rst_instr"}, instr, 16'h0000);
    chk_h({tag, "_rst_outs"},
          {9'd0, imem_req, dmem_req, dmem_we, rf_we, flags_we, halted, fault}, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_b({tag, "_idle_req"}, imem_req, 1'b0);
    @(negedge clk);
    chk_b({tag, "_fetch_req"}, imem_req, 1'b1);
  endtask

  // Called at the falling edge of the first FETCH cycle of an instruction.
  task automatic run_vec(input int idx, input vec_t v);
    int   cyc, iw, fw, rw, dreq, dwe;
    logic fetched, done;
    string p;
    p = $sformatf("v%0d", idx);
    cyc = 0; iw = 0; fw = 0; rw = 0; dreq = 0; dwe = 0;
    fetched = 1'b0; done = 1'b0;
    chk_h({p, "_fetch_addr"}, imem_addr, v.addr);
    imem_rdata = v.ins;
    dec_we = v.we; dec_sets_flags = v.sf; dec_load = v.ld; dec_store = v.st;
    dec_branch = v.br; dec_cond = v.cond; dec_br_offset = v.off; flags = v.flg;
    while (!done) begin
      cyc++;
      if (flags_we) fw++;
      if (rf_we) rw++;
      if (dmem_req) begin
        dreq++;
        if (dmem_we) dwe++;
      end
      imem_ack = 1'b0;
      if (imem_req && !fetched) begin
        if (iw == v.iw) begin
          imem_ack = 1'b1;
          fetched  = 1'b1;
        end
        iw++;
      end
      dmem_ack = dmem_req && (dreq > v.dw);
      @(negedge clk);
      if ((fetched && imem_req) || halted || fault) begin
        done = 1'b1;
      end else if (cyc >= 64) begin
        checks++;
        errors++;
        $display("FAIL %s_no_next_fetch: got none after %0d cycles expected %0d", p, cyc, v.lat);
        done = 1'b1;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk_i({p, "_latency"}, cyc, v.lat);
    chk_i({p, "_flags_we"}, fw, v.fw);
    chk_i({p, "_rf_we"}, rw, v.rw);
    chk_i({p, "_dmem_req"}, dreq, v.dreq);
    chk_i({p, "_dmem_we"}, dwe, v.dwe);
    chk_h({p, "_next_addr"}, imem_addr, v.nxt);
    chk_h({p, "_instr"}, instr, v.ins);
    chk_b({p, "_halt_fault"}, halted | fault, 1'b0);
  endtask

  vec_t vecs [26];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;

    //            ins       we sf ld st br cond   off       flg     iw dw addr      nxt       lat fw rw dq dwe
    vecs[0]  = mk(16'h1840, 1, 1, 0, 0, 0, 4'hE, 16'h0000, 4'b0000, 0, 0, 16'h0000, 16'h0002, 4, 1, 1, 0, 0); // ADDS
    vecs[1]  = mk(16'h4288, 0, 1, 0, 0, 0, 4'hE, 16'h0000, 4'b0000, 0, 0, 16'h0002, 16'h0004, 3, 1, 0, 0, 0); // CMP
    vecs[2]  = mk(16'hBF00, 0, 0, 0, 0, 0, 4'hE, 16'h0000, 4'b0000, 0, 0, 16'h0004, 16'h0006, 3, 0, 0, 0, 0); // NOP
    vecs[3]  = mk(16'h6808, 1, 0, 1, 0, 0, 4'hE, 16'h0000, 4'b0000, 0, 0, 16'h0006, 16'h0008, 5, 0, 1, 1, 0); // LDR
    vecs[4]  = mk(16'h6008, 0, 0, 0, 1, 0, 4'hE, 16'h0000, 4'b0000, 0, 0, 16'h0008, 16'h000A, 4, 0, 0, 1, 1); // STR
    vecs[5]  = mk(16'h6808, 1, 0, 1, 0, 0, 4'hE, 16'h0000, 4'b0000, 0, 3, 16'h000A, 16'h000C, 8, 0, 1, 4, 0); // LDR wait 3
    vecs[6]  = mk(16'h6008, 0, 0, 0, 1, 0, 4'hE, 16'h0000, 4'b0000, 0, 3, 16'h000C, 16'h000E, 7, 0, 0, 4, 4); // STR wait 3
    vecs[7]  = mk(16'h1840, 1, 1, 0, 0, 0, 4'hE, 16'h0000, 4'b0000, 2, 0, 16'h000E, 16'h0010, 6, 1, 1, 0, 0); // ADDS fetch wait 2
    vecs[8]  = mk(16'hD0F8, 0, 0, 0, 0, 1, 4'h0, 16'hFFF0, 4'b0100, 0, 0, 16'h0010, 16'h0002, 3, 0, 0, 0, 0); // EQ taken
    vecs[9]  = mk(16'hE006, 0, 0, 0, 0, 1, 4'hE, 16'h000C, 4'b0000, 0, 0, 16'h0002, 16'h0010, 3, 0, 0, 0, 0); // AL
    vecs[10] = mk(16'hD0F8, 0, 0, 0, 0, 1, 4'h0, 16'hFFF0, 4'b0000, 0, 0, 16'h0010, 16'h0012, 3, 0, 0, 0, 0); // EQ not taken
    vecs[11] = mk(16'hDFF8, 0, 0, 0, 0, 1, 4'hF, 16'hFFF0, 4'b0100, 0, 0, 16'h0012, 16'h0014, 3, 0, 0, 0, 0); // NV
    vecs[12] = mk(16'hD108, 0, 0, 0, 0, 1, 4'h1, 16'h0010, 4'b0000, 0, 0, 16'h0014, 16'h0026, 3, 0, 0, 0, 0); // NE taken
    vecs[13] = mk(16'hDA08, 0, 0, 0, 0, 1, 4'hA, 16'h0010, 4'b1000, 0, 0, 16'h0026, 16'h0028, 3, 0, 0, 0, 0); // GE not taken
    vecs[14] = mk(16'hDBFF, 0, 0, 0, 0, 1, 4'hB, 16'hFFFE, 4'b1000, 0, 0, 16'h0028, 16'h0028, 3, 0, 0, 0, 0); // LT taken
    vecs[15] = mk(16'hD880, 0, 0, 0, 0, 1, 4'h8, 16'h0100, 4'b0010, 0, 0, 16'h0028, 16'h012A, 3, 0, 0, 0, 0); // HI taken
    vecs[16] = mk(16'hD980, 0, 0, 0, 0, 1, 4'h9, 16'h0100, 4'b0010, 0, 0, 16'h012A, 16'h012C, 3, 0, 0, 0, 0); // LS not taken
    vecs[17] = mk(16'hDC02, 0, 0, 0, 0, 1, 4'hC, 16'h0004, 4'b0000, 0, 0, 16'h012C, 16'h0132, 3, 0, 0, 0, 0); // GT taken
    vecs[18] = mk(16'hDD02, 0, 0, 0, 0, 1, 4'hD, 16'h0004, 4'b0000, 0, 0, 16'h0132, 16'h0134, 3, 0, 0, 0, 0); // LE not taken
    vecs[19] = mk(16'hD4FF, 0, 0, 0, 0, 1, 4'h4, 16'h1000, 4'b1000, 0, 0, 16'h0134, 16'h1136, 3, 0, 0, 0, 0); // MI taken
    vecs[20] = mk(16'hD708, 0, 0, 0, 0, 1, 4'h7, 16'h0010, 4'b0001, 0, 0, 16'h1136, 16'h1138, 3, 0, 0, 0, 0); // VC not taken
    vecs[21] = mk(16'hE000, 0, 0, 0, 0, 1, 4'hE, 16'hF000, 4'b0000, 0, 0, 16'h1138, 16'h013A, 3, 0, 0, 0, 0); // AL wraps
    vecs[22] = mk(16'hD203, 0, 0, 0, 0, 1, 4'h2, 16'h0006, 4'b0010, 0, 0, 16'h013A, 16'h0142, 3, 0, 0, 0, 0); // CS taken
    vecs[23] = mk(16'hD303, 0, 0, 0, 0, 1, 4'h3, 16'h0006, 4'b0010, 0, 0, 16'h0142, 16'h0144, 3, 0, 0, 0, 0); // CC not taken
    vecs[24] = mk(16'hD601, 0, 0, 0, 0, 1, 4'h6, 16'h0002, 4'b0001, 0, 0, 16'h0144, 16'h0148, 3, 0, 0, 0, 0); // VS taken
    vecs[25] = mk(16'hD5FC, 0, 0, 0, 0, 1, 4'h5, 16'hFFF8, 4'b0000, 0, 0, 16'h0148, 16'h0142, 3, 0, 0, 0, 0); // PL taken

    do_reset("init");
    for (int i = 0; i < 26; i++) begin
      run_vec(i, vecs[i]);
    end

    // Fetch never acknowledged: fault after 8 waiting cycles.
    do_reset("tmo");
    waited = 0;
    while (imem_req && !fault && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    chk_i("tmo_wait_cycles", waited, 8);
    chk_b("tmo_fault", fault, 1'b1);
    chk_b("tmo_req_dropped", imem_req, 1'b0);
    repeat (3) @(negedge clk);
    chk_h("tmo_still_quiet", {13'd0, fault, imem_req, dmem_req}, 16'h0004);
    chk_h("tmo_pc", pc, 16'h0000);

    // Ack on the 8th waiting cycle wins over the timeout.
    do_reset("late");
    repeat (7) @(negedge clk);
    chk_b("late_req_cycle8", imem_req, 1'b1);
    chk_b("late_nofault_cycle8", fault, 1'b0);
    imem_rdata = 16'hBF00;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk_b("late_nofault", fault, 1'b0);
    chk_b("late_decode_req", imem_req, 1'b0);
    repeat (2) @(negedge clk);
    chk_b("late_next_req", imem_req, 1'b1);
    chk_h("late_next_addr", imem_addr, 16'h0002);
    @(negedge clk);
    chk_b("late_cnt_cleared", fault, 1'b0);

    // Breakpoint halts after DECODE with pc past the BKPT.
    do_reset("bkpt");
    imem_rdata = 16'hBE00;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk_b("bkpt_not_yet", halted, 1'b0);
    @(negedge clk);
    chk_b("bkpt_halted", halted, 1'b1);
    chk_h("bkpt_pc", pc, 16'h0002);
    chk_h("bkpt_instr", instr, 16'hBE00);
    repeat (3) @(negedge clk);
    chk_h("bkpt_stays", {12'd0, halted, imem_req, dmem_req, rf_we}, 16'h0008);
    reset = 1'b0;
    #1;
    chk_b("bkpt_reset_clears", halted, 1'b0);
    chk_h("bkpt_reset_pc", pc, 16'h0000);

    // Reset asserted mid-MEM aborts the load immediately.
    do_reset("rmem");
    dec_load = 1'b1;
    dec_we = 1'b1;
    imem_rdata = 16'h6808;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_b("rmem_dmem_req", dmem_req, 1'b1);
    chk_h("rmem_pc_before", pc, 16'h0002);
    #2;
    reset = 1'b0;
    #1;
    chk_h("rmem_outs_cleared",
          {9'd0, imem_req, dmem_req, dmem_we, rf_we, flags_we, halted, fault}, 16'h0000);
    chk_h("rmem_pc", pc, 16'h0000);
    dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk_b("rmem_no_completion", rf_we, 1'b0);
    chk_b("rmem_no_req", dmem_req, 1'b0);
    dmem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit Thumb-subset core; owns the PC and the instruction register (IR).
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Feeds the IR to the instruction decoder and gates the decoder's register-file write and flag updates into the correct cycle.
- Evaluates branch conditions, arbitrates instruction-memory and data-memory handshakes, and detects bus timeout and breakpoint halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 8'd255, max cycles a memory request may wait for ack before fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  16  fetch byte address (= pc).
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  16  fetched instruction.
- instr  out  16  IR contents, to decoder.
- dec_we  in  1  decoded instruction writes a register.
- dec_sets_flags  in  1  decoded instruction updates NZCV.
- dec_load  in  1  decoded instruction is a load.
- dec_store  in  1  decoded instruction is a store.
- dec_branch  in  1  decoded instruction is a branch.
- dec_cond  in  4  branch condition (4'b1110 = always).
- dec_br_offset  in  16  sign-extended byte offset.
- flags  in  4  current NZCV {N,Z,C,V}.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write (store).
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- flags_we  out  1  NZCV register update strobe.
- pc  out  16  program counter.
- halted  out  1  breakpoint halt reached.
- fault  out  1  memory timeout fault.

Behaviour:
- Reset (async, reset=0): state=IDLE, pc=RESET_PC, instr=0, cycle counter=0; every output 0 except pc. Reset asserted mid-operation aborts the operation at once, with no completion.
- States and transitions:
  - IDLE -> FETCH on the next edge.
  - FETCH -> DECODE on ack.
  - DECODE -> EXEC.
  - EXEC -> MEM when load or store.
  - EXEC -> WB when dec_we is set (non-memory).
  - EXEC -> FETCH otherwise.
  - MEM -> WB on ack for a load.
  - MEM -> FETCH on ack for a store.
  - WB -> FETCH.
  - HALT and FAULT are terminal; only reset leaves them.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack is sampled high.
  - On the ack edge: instr<=imem_rdata, pc<=pc+2 (mod 2^16), imem_req drops the next cycle.
  - Ack while req=0 is ignored.
- DECODE: if instr==16'hBE00 (BKPT), go to HALT and set halted=1; pc is not rolled back.
- EXEC:
  - flags_we=1 for one cycle iff dec_sets_flags.
  - Branch taken iff condition passes: pc<=pc+dec_br_offset (mod 2^16), computed from the already-incremented pc.
  - Condition codes follow ARM encoding 0000-1101. 1110 = always. 1111 = never (treated as NOP).
- MEM:
  - dmem_req=1, and dmem_we=dec_store, held until dmem_ack.
  - If dmem_ack is already high on the first MEM cycle, the access completes in 1 cycle.
- WB: rf_we=1 for exactly one cycle. rf_we is never asserted in any other state.
- Timeout:
  - The counter increments each cycle that FETCH or MEM waits without ack, and clears on ack or state exit.
  - When the counter reaches TIMEOUT: go to FAULT, set fault=1, deassert all requests and strobes.
  - Ack arriving in the same cycle the count hits TIMEOUT wins; no fault.
- Zero-wait latencies:
  - ALU with writeback: 4 cycles.
  - Flag-only or no-op: 3 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Outputs are Moore, decoded from state, except pc and instr, which are registers.

Test Plan:
- Reset release, RESET_PC=0, zero-wait imem returning ADDS (dec_we=1, dec_sets_flags=1) -> imem_req high 1 cycle after release; flags_we in cycle 3; rf_we in cycle 4; next fetch at pc=2.
- Branch at pc=0x0010, dec_cond=0000 (EQ), offset=16'hFFF0: with Z=1 -> next fetch address 0x0002; with Z=0 -> next fetch 0x0012. dec_cond=1111 -> always 0x0012.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, single rf_we pulse after ack; same for store -> dmem_we=1 and no rf_we.
- imem_ack never asserted, TIMEOUT=8 -> fault=1 after 8 waiting cycles, imem_req=0 thereafter. Ack arriving on cycle 8 instead -> no fault.
- instr=16'hBE00 -> halted=1 after DECODE, no further requests, pc=addr+2. Reset pulse -> halted=0, pc=RESET_PC.
- Reset asserted mid-MEM with dmem_req high -> dmem_req, rf_we and all strobes 0 immediately, pc=RESET_PC.
